// File: rtl/silife_grid.sv
// silife_grid: Game-of-Life cell array, one row of the next generation per
// clock. The row being rewritten needs the old contents of the row above it
// (already overwritten) and, on a torus, the old row 0 when it reaches the
// last row, so both are kept in shadow registers while the sweep runs.
module silife_grid #(
   parameter int          WIDTH        = 8,
   parameter int          HEIGHT       = 8,
   parameter int          GEN_W        = 16,
   parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0]  SURVIVE_MASK = 9'b000001100
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        step,
   input  logic                        wrap,
   input  logic                        wr_en,
   input  logic [$clog2(HEIGHT)-1:0]   wr_row,
   input  logic [$clog2(WIDTH)-1:0]    wr_col,
   input  logic                        wr_data,
   input  logic [$clog2(HEIGHT)-1:0]   rd_row,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        busy,
   output logic                        done,
   output logic [GEN_W-1:0]            generation,
   output logic                        empty
);

   localparam int RW = $clog2(HEIGHT);
   localparam int CW = $clog2(WIDTH);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      COMPUTE = 1'b1
   } state_t;

   state_t              state_r;
   logic [RW-1:0]       row_r;
   logic                wrap_r;
   logic [WIDTH-1:0]    grid_r [HEIGHT];
   logic [WIDTH-1:0]    prev_old_r;
   logic [WIDTH-1:0]    first_old_r;

   logic [RW-1:0]       row_next_s;
   logic [WIDTH-1:0]    above_s;
   logic [WIDTH-1:0]    cur_s;
   logic [WIDTH-1:0]    below_s;
   logic [WIDTH-1:0]    new_row_s;
   logic [3:0]          cnt_s;
   logic                any_live_s;

   // Column lookup with edge handling: off-grid columns wrap or read dead.
   function automatic logic cell_at(input logic [WIDTH-1:0] row, input int idx,
                                    input logic wrap_en);
      logic v;
      if (idx < 0) begin
         v = wrap_en ? row[WIDTH-1] : 1'b0;
      end else if (idx >= WIDTH) begin
         v = wrap_en ? row[0] : 1'b0;
      end else begin
         v = row[CW'(idx)];
      end
      return v;
   endfunction

   // Live-neighbour count (0..8) of column c given the three relevant rows.
   function automatic logic [3:0] count_at(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] m,
                                           input logic [WIDTH-1:0] b,
                                           input int c, input logic wrap_en);
      logic [3:0] n;
      n = 4'd0;
      for (int d = -1; d <= 1; d++) begin
         n = n + {3'b000, cell_at(a, c + d, wrap_en)} + {3'b000, cell_at(b, c + d, wrap_en)};
         if (d != 0) begin
            n = n + {3'b000, cell_at(m, c + d, wrap_en)};
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Assemble the neighbourhood of the current row and apply the rule masks.
   always_comb begin
      row_next_s = (row_r == LAST_ROW) ? {RW{1'b0}} : row_r + RW'(1);
      cur_s      = grid_r[row_r];
      cnt_s      = 4'd0;
      new_row_s  = {WIDTH{1'b0}};
      if (row_r == {RW{1'b0}}) begin
         above_s = wrap_r ? grid_r[LAST_ROW] : {WIDTH{1'b0}};
      end else begin
         above_s = prev_old_r;
      end
      if (row_r == LAST_ROW) begin
         below_s = wrap_r ? first_old_r : {WIDTH{1'b0}};
      end else begin
         below_s = grid_r[row_next_s];
      end
      for (int c = 0; c < WIDTH; c++) begin
         cnt_s        = count_at(above_s, cur_s, below_s, c, wrap_r);
         new_row_s[c] = cur_s[c] ? SURVIVE_MASK[cnt_s] : BIRTH_MASK[cnt_s];
      end
   end

   // Emptiness flag straight from the cell array.
   always_comb begin
      any_live_s = 1'b0;
      for (int r = 0; r < HEIGHT; r++) begin
         any_live_s = any_live_s | (|grid_r[r]);
      end
      empty = ~any_live_s;
   end

   // Control FSM, cell array, write port and registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         row_r       <= {RW{1'b0}};
         wrap_r      <= 1'b0;
         prev_old_r  <= {WIDTH{1'b0}};
         first_old_r <= {WIDTH{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         generation  <= {GEN_W{1'b0}};
         rd_data     <= {WIDTH{1'b0}};
         for (int r = 0; r < HEIGHT; r++) begin
            grid_r[r] <= {WIDTH{1'b0}};
         end
      end else begin
         done <= 1'b0;
         if (int'(rd_row) < HEIGHT) begin
            rd_data <= grid_r[rd_row];
         end else begin
            rd_data <= {WIDTH{1'b0}};
         end
         case (state_r)
            IDLE: begin
               if (wr_en) begin
                  // a write wins over a simultaneous step, which is dropped
                  if ((int'(wr_row) < HEIGHT) && (int'(wr_col) < WIDTH)) begin
                     grid_r[wr_row][wr_col] <= wr_data;
                  end
               end else if (step) begin
                  state_r <= COMPUTE;
                  wrap_r  <= wrap;
                  row_r   <= {RW{1'b0}};
                  busy    <= 1'b1;
               end
            end
            COMPUTE: begin
               grid_r[row_r] <= new_row_s;
               prev_old_r    <= cur_s;
               if (row_r == {RW{1'b0}}) begin
                  first_old_r <= cur_s;
               end
               if (row_r == LAST_ROW) begin
                  state_r    <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  generation <= generation + GEN_W'(1);
               end else begin
                  row_r <= row_next_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
